// File: rtl/mio_arbiter.sv
// rtl/mio_arbiter.sv - two-master, one-slave memory bus arbiter with ack timeout
module mio_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] rdata,
  output logic          bus_err,
  output logic [1:0]    grant,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  // Last ACCESS cycle index before the access is abandoned
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_m1;
  logic [7:0] wait_cnt;
  logic       any_req;
  logic       win_m1;
  logic       wait_expired;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: issue on any request, finish on ack or timeout, one DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: if (mem_ack || wait_expired) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Arbitration winner and timeout detection
  always_comb begin
    any_req      = m0_req | m1_req;
    // m1 wins alone, or on a tie in round-robin mode when m0 was served last
    win_m1       = m1_req & (~m0_req | ((FIXED_PRIO == 0) & ~last_m1));
    wait_expired = (wait_cnt == WAIT_LAST);
  end

  // Registered bus strobes, owner tracking, completion pulses and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= 2'b00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= 8'd0;
      last_m1   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            mem_en    <= 1'b1;
            mem_we    <= win_m1 ? m1_we    : m0_we;
            mem_addr  <= win_m1 ? m1_addr  : m0_addr;
            mem_wdata <= win_m1 ? m1_wdata : m0_wdata;
            grant     <= win_m1 ? 2'b10    : 2'b01;
            last_m1   <= win_m1;
            wait_cnt  <= 8'd0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            m0_ready <= grant[0];
            m1_ready <= grant[1];
          end else if (wait_expired) begin
            if (!mem_we) rdata <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            m0_ready <= grant[0];
            m1_ready <= grant[1];
            bus_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          bus_err  <= 1'b0;
          grant    <= 2'b00;
        end
        default: begin
          grant  <= 2'b00;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// tb/tb_mio_arbiter.sv - self-checking bench for mio_arbiter with randomized scoreboard
module tb_mio_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  // dut_a: round-robin, TIMEOUT=8; dut_b: fixed priority, TIMEOUT=4
  logic        a_m0_ready, a_m1_ready, a_bus_err, a_mem_en, a_mem_we, a_mem_ack;
  logic [1:0]  a_grant;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, rv_a;
  logic        b_m0_ready, b_m1_ready, b_bus_err, b_mem_en, b_mem_we, b_mem_ack;
  logic [1:0]  b_grant;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, rv_b;

  int   dly_a, dly_b, cnt_a, cnt_b;
  logic spur_a;
  int   errors, checks;

  mio_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(a_m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(a_m1_ready),
    .rdata(a_rdata), .bus_err(a_bus_err), .grant(a_grant),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(rv_a), .mem_ack(a_mem_ack)
  );

  mio_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(b_m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(b_m1_ready),
    .rdata(b_rdata), .bus_err(b_bus_err), .grant(b_grant),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(rv_b), .mem_ack(b_mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: ack in the dly-th cycle of a strobe (0 = first cycle)
  always @(posedge clk) cnt_a <= a_mem_en ? cnt_a + 1 : 0;
  always @(posedge clk) cnt_b <= b_mem_en ? cnt_b + 1 : 0;
  assign a_mem_ack = (a_mem_en && cnt_a == dly_a) || spur_a;
  assign b_mem_ack = b_mem_en && cnt_b == dly_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; spur_a = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Ticks until a ready pulse on the selected DUT; n counts ticks, -1 on expiry
  task automatic wait_ready(input bit sel_b, output int n, output logic [1:0] who);
    n = -1; who = 2'b00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!sel_b && (a_m0_ready || a_m1_ready)) begin n = i; who = {a_m1_ready, a_m0_ready}; break; end
      if (sel_b && (b_m0_ready || b_m1_ready)) begin n = i; who = {b_m1_ready, b_m0_ready}; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    tick(); tick();
    checks++;
    if ({a_grant, a_mem_en, a_mem_we, a_m0_ready, a_m1_ready, a_bus_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b expected 0000000", {a_grant, a_mem_en, a_mem_we, a_m0_ready, a_m1_ready, a_bus_err});
    end
    checks++;
    if ({a_rdata, a_mem_addr, a_mem_wdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data_a: got %h %h %h expected zeros", a_rdata, a_mem_addr, a_mem_wdata);
    end
    checks++;
    if ({b_grant, b_mem_en, b_mem_we, b_m0_ready, b_m1_ready, b_bus_err, b_rdata} !== 39'b0) begin
      errors++; $display("FAIL reset_b: got %b %h expected zeros", {b_grant, b_mem_en, b_mem_we, b_m0_ready, b_m1_ready, b_bus_err}, b_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_wdata = $urandom;
    dly_a = 0; rv_a = 32'h1234_5678;
    tick();
    checks++;
    if ({a_mem_en, a_grant, a_mem_addr} !== {1'b1, 2'b01, 32'h10}) begin
      errors++; $display("FAIL single_issue: got en=%b grant=%b addr=%h expected 1 01 00000010", a_mem_en, a_grant, a_mem_addr);
    end
    tick();
    checks++;
    if ({a_m0_ready, a_m1_ready, a_mem_en, a_grant, a_bus_err} !== 6'b100010) begin
      errors++; $display("FAIL single_done: got rdy0=%b rdy1=%b en=%b grant=%b err=%b expected 1 0 0 01 0", a_m0_ready, a_m1_ready, a_mem_en, a_grant, a_bus_err);
    end
    checks++;
    if (a_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL single_rdata: got %h expected 12345678", a_rdata);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if ({a_m0_ready, a_grant} !== 3'b000) begin
      errors++; $display("FAIL single_idle: got rdy0=%b grant=%b expected 0 00", a_m0_ready, a_grant);
    end
  endtask

  task automatic test_write_delay();
    int  k;
    bit  stable;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0400; m1_wdata = 32'hCAFE_F00D;
    dly_a = 5; rv_a = 32'hDEAD_BEEF;
    tick();
    k = 0; stable = 1'b1;
    while (a_mem_en && k < 20) begin
      k++;
      if ({a_mem_we, a_mem_addr, a_mem_wdata, a_grant} !== {1'b1, 32'h400, 32'hCAFE_F00D, 2'b10}) stable = 1'b0;
      tick();
    end
    checks++;
    if (k != 6) begin errors++; $display("FAIL write_en_cycles: got %0d expected 6", k); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL write_stable: got %b expected 1", stable); end
    checks++;
    if ({a_m1_ready, a_m0_ready, a_bus_err, a_rdata} !== {3'b100, 32'h1234_5678}) begin
      errors++; $display("FAIL write_done: got rdy1=%b rdy0=%b err=%b rdata=%h expected 1 0 0 12345678", a_m1_ready, a_m0_ready, a_bus_err, a_rdata);
    end
    m1_req = 1'b0;
    tick();
    checks++;
    if (a_m1_ready !== 1'b0) begin errors++; $display("FAIL write_pulse: got %b expected 0", a_m1_ready); end
  endtask

  task automatic test_alternate();
    int         n;
    logic [1:0] who;
    logic [1:0] exp_who;
    do_reset();
    dly_a = 1; rv_a = 32'h0BAD_0001;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_who = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(1'b0, n, who);
      checks++;
      if (who !== exp_who) begin errors++; $display("FAIL alternate_%0d: got owner %b expected %b", i, who, exp_who); end
      if (who[0]) m0_req = 1'b0;
      if (who[1]) m1_req = 1'b0;
      tick();
      m0_req = 1'b1; m1_req = 1'b1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fixed_prio();
    int         n;
    logic [1:0] who;
    do_reset();
    dly_b = 0; rv_b = 32'h0000_0055;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready(1'b1, n, who);
      checks++;
      if (who !== 2'b01) begin errors++; $display("FAIL fixed_prio_%0d: got owner %b expected 01", i, who); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ack_last();
    int         n;
    logic [1:0] who;
    dly_b = 3; rv_b = 32'hA5C3_0000 | 32'($urandom_range(1, 65535));
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom;
    wait_ready(1'b1, n, who);
    checks++;
    if (n != 5 || who !== 2'b01) begin errors++; $display("FAIL ack_last_timing: got n=%0d owner=%b expected 5 01", n, who); end
    checks++;
    if ({b_bus_err, b_rdata} !== {1'b0, rv_b}) begin
      errors++; $display("FAIL ack_last_data: got err=%b rdata=%h expected 0 %h", b_bus_err, b_rdata, rv_b);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int k;
    dly_b = 255;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0020;
    tick();
    k = 0;
    while (b_mem_en && k < 20) begin k++; tick(); end
    checks++;
    if (k != 4) begin errors++; $display("FAIL timeout_en_cycles: got %0d expected 4", k); end
    checks++;
    if ({b_m0_ready, b_bus_err, b_grant, b_rdata} !== {4'b1101, 32'h0}) begin
      errors++; $display("FAIL timeout_done: got rdy=%b err=%b grant=%b rdata=%h expected 1 1 01 0", b_m0_ready, b_bus_err, b_grant, b_rdata);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if ({b_m0_ready, b_bus_err} !== 2'b00) begin errors++; $display("FAIL timeout_pulse: got %b expected 00", {b_m0_ready, b_bus_err}); end
    dly_b = 0;
  endtask

  task automatic test_reset_mid_access();
    int         n;
    logic [1:0] who;
    do_reset();
    dly_a = 0; rv_a = 32'h600D_0001;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0030;
    wait_ready(1'b0, n, who);
    m0_req = 1'b0;
    tick();
    checks++;
    if (a_rdata !== 32'h600D_0001) begin errors++; $display("FAIL pre_reset_rdata: got %h expected 600d0001", a_rdata); end
    dly_a = 255; rv_a = 32'h7777_7777;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a_mem_en, a_grant, a_m1_ready, a_rdata} !== 36'b0) begin
      errors++; $display("FAIL reset_abort: got en=%b grant=%b rdy1=%b rdata=%h expected 0 00 0 0", a_mem_en, a_grant, a_m1_ready, a_rdata);
    end
    reset = 1'b0; m1_req = 1'b0;
    tick();
    dly_a = 2; rv_a = 32'h1357_9BDF;
    m0_req = 1'b1;
    wait_ready(1'b0, n, who);
    checks++;
    if (n != 4 || who !== 2'b01 || a_rdata !== 32'h1357_9BDF) begin
      errors++; $display("FAIL after_reset: got n=%0d owner=%b rdata=%h expected 4 01 13579bdf", n, who, a_rdata);
    end
    m0_req = 1'b0;
    tick();
    rv_a = 32'hFFFF_0000; spur_a = 1'b1;
    tick(); tick();
    spur_a = 1'b0;
    checks++;
    if ({a_rdata, a_mem_en, a_m0_ready, a_m1_ready} !== {32'h1357_9BDF, 3'b000}) begin
      errors++; $display("FAIL spurious_ack: got rdata=%h en=%b expected 13579bdf 0", a_rdata, a_mem_en);
    end
  endtask

  // Transaction-level scoreboard: pending requests per master, round-robin tie rule
  task automatic test_random();
    bit          pend0, pend1, last1, w1, exp_we, tmo;
    logic [31:0] rdata_m, exp_addr;
    int          d, n;
    logic [1:0]  who;
    do_reset();
    pend0 = 0; pend1 = 0; last1 = 1; rdata_m = 32'h0;
    for (int it = 0; it < 30; it++) begin
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom;
      end
      if (!pend0 && !pend1) begin
        pend0 = 1; m0_we = 1'b0; m0_addr = $urandom; m0_wdata = $urandom;
      end
      m0_req = pend0; m1_req = pend1;
      if (pend0 && pend1) w1 = !last1;
      else                w1 = pend1;
      d = $urandom_range(0, 9); dly_a = d; rv_a = $urandom;
      tmo      = (d >= 8);
      exp_we   = w1 ? m1_we : m0_we;
      exp_addr = w1 ? m1_addr : m0_addr;
      if (!exp_we) rdata_m = tmo ? 32'h0 : rv_a;
      wait_ready(1'b0, n, who);
      checks++;
      if (n != (tmo ? 9 : d + 2) || who !== (w1 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rand_%0d_owner: got n=%0d owner=%b expected n=%0d owner=%b", it, n, who, tmo ? 9 : d + 2, w1 ? 2'b10 : 2'b01);
      end
      checks++;
      if ({a_bus_err, a_rdata, a_mem_addr, a_grant} !== {tmo, rdata_m, exp_addr, (w1 ? 2'b10 : 2'b01)}) begin
        errors++; $display("FAIL rand_%0d_data: got err=%b rdata=%h addr=%h grant=%b expected %b %h %h", it, a_bus_err, a_rdata, a_mem_addr, a_grant, tmo, rdata_m, exp_addr);
      end
      if (w1) begin pend1 = 0; m1_req = 1'b0; end
      else    begin pend0 = 0; m0_req = 1'b0; end
      last1 = w1;
      tick();
      checks++;
      if ({a_grant, a_m0_ready, a_m1_ready, a_bus_err} !== 5'b0) begin
        errors++; $display("FAIL rand_%0d_idle: got %b expected 00000", it, {a_grant, a_m0_ready, a_m1_ready, a_bus_err});
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    errors = 0; checks = 0;
    dly_a = 0; dly_b = 0; rv_a = '0; rv_b = '0; spur_a = 1'b0;
    test_reset();
    test_single_read();
    test_write_delay();
    test_alternate();
    test_fixed_prio();
    test_ack_last();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
Name: mio_arbiter

Overview:
Two-master, one-slave memory bus arbiter. It shares the single-ported memory/IO bus between the multi-cycle CPU controller (master 0, the MemRead/MemWrite/MIO_ready handshake) and a second master such as a video or DMA engine (master 1). It sequences each access as issue, then wait for slave ack (with timeout), then a one-cycle ready pulse back to the owning master.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, maximum ACCESS cycles before aborting with bus error (1..255)
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  CPU access request (MemRead|MemWrite)
m0_we  in  1  CPU write enable
m0_addr  in  AW  CPU address
m0_wdata  in  DW  CPU write data
m0_ready  out  1  one-cycle completion pulse to CPU (MIO_ready)
m1_req  in  1  master 1 request
m1_we  in  1  master 1 write enable
m1_addr  in  AW  master 1 address
m1_wdata  in  DW  master 1 write data
m1_ready  out  1  one-cycle completion pulse to master 1
rdata  out  DW  registered read data, shared by both masters
bus_err  out  1  one-cycle pulse with ready when the access timed out
grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 00 when idle
mem_en  out  1  slave access strobe
mem_we  out  1  slave write enable
mem_addr  out  AW  slave address
mem_wdata  out  DW  slave write data
mem_rdata  in  DW  slave read data, valid with mem_ack
mem_ack  in  1  slave completion; may be asserted in the first mem_en cycle

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) forces state=IDLE, grant=00, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, m0_ready=0, m1_ready=0, bus_err=0, wait counter=0, last_grant=m1, so m0 wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE: requests are sampled only in this state.
  - If no request, stay in IDLE.
  - Otherwise choose a winner:
    - Single requester wins.
    - Both requesting: FIXED_PRIO=1 gives m0. FIXED_PRIO=0 gives the master not in last_grant.
  - Winner's we/addr/wdata are latched into mem_we/mem_addr/mem_wdata. Set mem_en=1, grant=winner, last_grant=winner, counter=0, go to ACCESS.
- ACCESS: mem_en held at 1 and address/data held stable.
  - mem_ack=1: rdata <= mem_rdata on reads (unchanged on writes); mem_en<=0, mem_we<=0; the owner's ready<=1; go to DONE.
  - Else if counter==TIMEOUT-1: mem_en<=0; ready<=1 and bus_err<=1; rdata<=0 on reads; go to DONE.
  - Else counter+1.
  - mem_ack and timeout in the same cycle: ack wins, bus_err=0.
- DONE: ready/bus_err are high for exactly this one cycle. Next edge: ready=0, bus_err=0, grant=00, go to IDLE.
- Latency: request seen in IDLE at cycle t; mem_en=1 from t+1; ack at t+1 gives ready at t+2. Minimum 3 cycles between back-to-back grants.
- Master rules:
  - Hold req/we/addr/wdata stable until its ready pulse.
  - Deassert req on the edge after ready, or it is served again.
  - The non-owning master's req may change freely; it is ignored until IDLE.
- mem_ack in IDLE or DONE is ignored and has no effect on rdata.
- Reset mid-ACCESS aborts the access: no ready pulse, mem_en=0 next cycle. The slave must tolerate a dropped strobe.
- The counter never exceeds TIMEOUT-1 and does not wrap.

Test Plan:
- m0 read addr 0x0000_0010, slave acks on the first mem_en cycle with 0x1234_5678 -> mem_en high 1 cycle, m0_ready pulse at t+2, rdata=0x1234_5678, grant=01 during ACCESS/DONE, bus_err=0.
- m0 and m1 both request from reset with FIXED_PRIO=0, each re-requesting after service -> grants alternate m0,m1,m0,m1; with FIXED_PRIO=1 and both held, only m0 is served.
- m1 write 0xCAFE_F00D to 0x0000_0400, ack delayed 5 cycles -> mem_addr/mem_wdata/mem_we stable for 6 ACCESS cycles, m1_ready one pulse, rdata unchanged.
- TIMEOUT=4, m0 read, no ack -> mem_en high exactly 4 cycles, then m0_ready=1 and bus_err=1 together for 1 cycle, rdata=0.
- TIMEOUT=4, ack arrives in the 4th ACCESS cycle -> normal completion, bus_err=0, rdata = slave data.
- reset asserted in the 2nd ACCESS cycle of an m1 read -> next cycle mem_en=0, grant=00, no m1_ready, rdata=0; after release an m0 request is served normally. A spurious mem_ack in IDLE leaves rdata unchanged.
